fft_out_serializer: RTL

FFT_OUT_SERIALIZER -- requirements
Module: fft_out_serializer

---
 rtl/fft_out_serializer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/fft_out_serializer.sv
// Serializes one captured 8-point FFT result into a valid/ready sample stream.
// Optional macro FFT_OUT_BITREV_EN emits slots in 3-bit bit-reversed order.
module fft_slot_reg #(
    parameter int DW = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          load,
    input  logic [DW-1:0] x_in,
    input  logic [DW-1:0] y_in,
    output logic [DW-1:0] x,
    output logic [DW-1:0] y
);
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            x <= '0;
            y <= '0;
        end else if (load) begin
            x <= x_in;
            y <= y_in;
        end
    end
endmodule

module fft_out_serializer #(
    parameter int DW = 16
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            frame_valid,
    input  logic [8*DW:0]   xout_in,
    input  logic [8*DW:0]   yout_in,
    output logic            frame_ready,
    output logic            sample_valid,
    input  logic            sample_ready,
    output logic [DW-1:0]   sample_x,
    output logic [DW-1:0]   sample_y,
    output logic [2:0]      sample_idx,
    output logic            sample_last,
    output logic            overrun,
    input  logic            clr_overrun
);
    localparam int NUM_SLOTS = 8;

    typedef enum logic {IDLE, STREAM} state_t;

    typedef struct packed {
        logic [DW-1:0] x;
        logic [DW-1:0] y;
        logic [2:0]    idx;
        logic          last;
    } sample_t;

    state_t                          state, state_nxt;
    logic [2:0]                      pos, pos_nxt;
    logic [2:0]                      slot;
    logic                            capture;
    logic [NUM_SLOTS-1:0][DW-1:0]    cap_x, cap_y;
    sample_t                         smp;
    logic                            unused_msb;

    // The top bit of each bus carries no sample data.
    assign unused_msb = xout_in[8*DW] ^ yout_in[8*DW];

    genvar k;
    generate
        for (k = 0; k < NUM_SLOTS; k++) begin : g_slot
            fft_slot_reg #(.DW(DW)) u_slot (
                .clock (clock),
                .reset (reset),
                .load  (capture),
                .x_in  (xout_in[DW*k +: DW]),
                .y_in  (yout_in[DW*k +: DW]),
                .x     (cap_x[k]),
                .y     (cap_y[k])
            );
        end
    endgenerate

`ifdef FFT_OUT_BITREV_EN
    assign slot = {pos[0], pos[1], pos[2]};
`else
    assign slot = pos;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            pos   <= '0;
        end else begin
            state <= state_nxt;
            pos   <= pos_nxt;
        end
    end

    // A new frame may be taken over the final handshake of the current one,
    // so back-to-back frames stream without a bubble.
    always_comb begin
        state_nxt    = state;
        pos_nxt      = pos;
        frame_ready  = 1'b0;
        sample_valid = 1'b0;
        capture      = 1'b0;
        case (state)
            IDLE: begin
                frame_ready = 1'b1;
                if (frame_valid) begin
                    capture   = 1'b1;
                    pos_nxt   = '0;
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                sample_valid = 1'b1;
                frame_ready  = (pos == 3'd7) && sample_ready;
                if (sample_ready) begin
                    pos_nxt = pos + 3'd1;
                    if (pos == 3'd7) begin
                        if (frame_valid) capture = 1'b1;
                        else             state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                pos_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            overrun <= 1'b0;
        else if (frame_valid && !frame_ready)
            overrun <= 1'b1;
        else if (clr_overrun)
            overrun <= 1'b0;
    end

    always_comb begin
        smp.x    = cap_x[slot];
        smp.y    = cap_y[slot];
        smp.idx  = slot;
        smp.last = (pos == 3'd7);
    end

    assign sample_x    = smp.x;
    assign sample_y    = smp.y;
    assign sample_idx  = smp.idx;
    assign sample_last = smp.last;
endmodule
